// File: rtl/simon_pkg.sv
// simon_pkg
// Shared constants and helpers for the player-input path.
//   NUM_BTNS            : number of physical push buttons
//   DEBOUNCE_CYCLES_DEF : default debounce hold time (5 ms at 100 MHz)
//   BTN_0..BTN_3        : button indices, identical to the decoder's encoding
//   db_state_t          : debounce cell state (stable low / stable high)
//   rise_count()        : number of set bits in a rise-event vector
package simon_pkg;

    localparam int NUM_BTNS            = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    localparam int BTN_0 = 0;
    localparam int BTN_1 = 1;
    localparam int BTN_2 = 2;
    localparam int BTN_3 = 3;

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } db_state_t;

    function automatic logic [2:0] rise_count(input logic [NUM_BTNS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
// Groups the button-path signals between the pins/game logic and the
// conditioner.
//   btn_raw    : raw, asynchronous, active-high button levels
//   accept_en  : game is accepting player input
//   btn_pulse  : one-cycle one-hot press strobe (or all zero)
//   btn_held   : debounced button levels
//   press_drop : one-cycle strobe, a debounced press was discarded
// Modports: master = the side driving the buttons / consuming the results,
//           slave  = the conditioner itself.
interface button_conditioner_if;
    import simon_pkg::*;

    logic [NUM_BTNS-1:0] btn_raw;
    logic                accept_en;
    logic [NUM_BTNS-1:0] btn_pulse;
    logic [NUM_BTNS-1:0] btn_held;
    logic                press_drop;

    modport master (
        output btn_raw,
        output accept_en,
        input  btn_pulse,
        input  btn_held,
        input  press_drop
    );

    modport slave (
        input  btn_raw,
        input  accept_en,
        output btn_pulse,
        output btn_held,
        output press_drop
    );

endinterface

// File: rtl/debounce_cell.sv
// debounce_cell
// One button: 2-flop synchroniser followed by a counter-based debouncer.
// The debounced level db only changes after the synchronised input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce back
// restarts the count.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw button level (asynchronous to clk)
//   db         : debounced level
//   rise       : one-cycle strobe, registered alongside db going 0->1
module debounce_cell
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_p0;
    logic            sync_p1;
    db_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign db = (state == STABLE_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            state   <= STABLE_LO;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            // synchroniser stage boundary
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            if (sync_p1 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // counter never exceeds CNT_LAST, so it cannot wrap
                cnt <= '0;
                case (state)
                    STABLE_LO: begin
                        state <= STABLE_HI;
                        rise  <= 1'b1;
                    end
                    STABLE_HI: state <= STABLE_LO;
                    default:   state <= STABLE_LO;
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
// Synchronises and debounces NUM_BTNS raw buttons and turns single accepted
// rise events into one-hot press pulses. Chords (two or more rises in the
// same cycle) and presses while input is disabled are dropped and flagged.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : button_conditioner_if.slave (btn_raw, accept_en in;
//           btn_pulse, btn_held, press_drop out)
// Build option: define BTN_LOCKOUT_EN to also drop a single press while any
// other button is already held.
module button_conditioner
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTNS-1:0] db;
    logic [NUM_BTNS-1:0] rise;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (bus.btn_raw[i]),
            .db   (db[i]),
            .rise (rise[i])
        );
    end

    logic [NUM_BTNS-1:0] held_p1;
    logic [NUM_BTNS-1:0] rise_p1;
    logic [NUM_BTNS-1:0] pulse_p2;
    logic                drop_p2;
    logic [NUM_BTNS-1:0] pulse_d;
    logic                drop_d;
    logic [2:0]          n_rise;

    assign n_rise = rise_count(rise_p1);

    // Rise events are judged together with the btn_held value that already
    // shows them, so accept_en and lockout see the same cycle as the event.
    always_comb begin
        pulse_d = '0;
        drop_d  = 1'b0;
        if (n_rise > 3'd1) begin
            drop_d = 1'b1;
        end else if (n_rise == 3'd1) begin
            if (!bus.accept_en) begin
                drop_d = 1'b1;
`ifdef BTN_LOCKOUT_EN
            end else if ((held_p1 & ~rise_p1) != '0) begin
                drop_d = 1'b1;
`endif
            end else begin
                pulse_d = rise_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_p1  <= '0;
            rise_p1  <= '0;
            pulse_p2 <= '0;
            drop_p2  <= 1'b0;
        end else begin
            // alignment stage: debounced levels and their rise strobes
            held_p1  <= db;
            rise_p1  <= rise;
            // output stage: registered acceptance decision
            pulse_p2 <= pulse_d;
            drop_p2  <= drop_d;
        end
    end

    assign bus.btn_held   = held_p1;
    assign bus.btn_pulse  = pulse_p2;
    assign bus.press_drop = drop_p2;

endmodule
